// File: rtl/risc_imm_enc_if.sv
// Request/response bus for the immediate encoder.
// slave: encoder side; master: program-loader side.
interface risc_imm_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_imm_src;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;

  modport master (
    output in_valid, in_imm_src, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

  modport slave (
    input  in_valid, in_imm_src, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/risc_imm_enc.sv
// Immediate encoder: packs a signed immediate into the I/S/B/J bit positions
// of a base instruction word, flags unrepresentable immediates, and queues
// results in a small output FIFO. Saturating accept/error counters.
// Optional round-trip checker enabled by defining IMM_ENC_CHECK_EN.
module risc_imm_enc #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  risc_imm_enc_if.slave    bus,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             chk_mismatch
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {FMT_I = 2'b00, FMT_S = 2'b01, FMT_B = 2'b10, FMT_J = 2'b11} fmt_e;

  fmt_e        fmt;
  logic [31:0] imm_mask;
  logic [31:0] imm_field;
  logic        enc_err;
  logic [31:0] enc_word;

  logic [32:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic [CNT_W-1:0] enc_cnt_q, err_cnt_q;
  logic             push, pop;

  assign fmt = fmt_e'(bus.in_imm_src);

  // Per-format field placement and representability check.
  always_comb begin
    imm_mask  = '0;
    imm_field = '0;
    enc_err   = 1'b0;
    unique case (fmt)
      FMT_I: begin
        imm_mask  = 32'hFFF0_0000;
        imm_field = {bus.in_imm[11:0], 20'b0};
        enc_err   = ~(&bus.in_imm[31:11] | ~|bus.in_imm[31:11]);
      end
      FMT_S: begin
        imm_mask  = 32'hFE00_0F80;
        imm_field = {bus.in_imm[11:5], 13'b0, bus.in_imm[4:0], 7'b0};
        enc_err   = ~(&bus.in_imm[31:11] | ~|bus.in_imm[31:11]);
      end
      FMT_B: begin
        imm_mask  = 32'hFE00_0F80;
        imm_field = {bus.in_imm[12], bus.in_imm[10:5], 13'b0,
                     bus.in_imm[4:1], bus.in_imm[11], 7'b0};
        enc_err   = ~(&bus.in_imm[31:12] | ~|bus.in_imm[31:12]) | bus.in_imm[0];
      end
      FMT_J: begin
        imm_mask  = 32'hFFFF_F000;
        imm_field = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                     bus.in_imm[19:12], 12'b0};
        enc_err   = ~(&bus.in_imm[31:20] | ~|bus.in_imm[31:20]) | bus.in_imm[0];
      end
      default: ;
    endcase
    enc_word = (bus.in_base & ~imm_mask) | imm_field;
  end

  // in_ready depends only on occupancy, so a pop never frees a slot in the same cycle.
  assign bus.in_ready  = (cnt_q < FULL_CNT);
  assign bus.out_valid = (cnt_q != '0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.out_inst  = bus.out_valid ? mem_q[rd_ptr_q][31:0] : '0;
  assign bus.out_err   = bus.out_valid ? mem_q[rd_ptr_q][32]   : 1'b0;
  assign enc_cnt       = enc_cnt_q;
  assign err_cnt       = err_cnt_q;

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {enc_err, enc_word};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (push) begin
      if (enc_cnt_q != '1)            enc_cnt_q <= enc_cnt_q + 1'b1;
      if (enc_err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

`ifdef IMM_ENC_CHECK_EN
  logic [31:0] dec_imm;
  logic        chk_q;

  // Re-decode the encoded word with the core's decoder field mapping.
  always_comb begin
    dec_imm = '0;
    unique case (fmt)
      FMT_I: dec_imm = {{20{enc_word[31]}}, enc_word[31:20]};
      FMT_S: dec_imm = {{20{enc_word[31]}}, enc_word[31:25], enc_word[11:7]};
      FMT_B: dec_imm = {{19{enc_word[31]}}, enc_word[31], enc_word[7],
                        enc_word[30:25], enc_word[11:8], 1'b0};
      FMT_J: dec_imm = {{11{enc_word[31]}}, enc_word[31], enc_word[19:12],
                        enc_word[20], enc_word[30:21], 1'b0};
      default: ;
    endcase
  end

  // Sticky round-trip mismatch flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chk_q <= 1'b0;
    else if (push && !enc_err && dec_imm != bus.in_imm) chk_q <= 1'b1;
  end

  assign chk_mismatch = chk_q;
`else
  assign chk_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_risc_imm_enc.sv
// Scoreboard bench for risc_imm_enc: expected words are modelled at accept
// time and compared in order as the FIFO head is consumed.
module tb_risc_imm_enc;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 4;
  localparam int unsigned CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] enc_cnt, err_cnt;
  logic          chk_mismatch;

  risc_imm_enc_if bus ();

  risc_imm_enc #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .enc_cnt(enc_cnt), .err_cnt(err_cnt), .chk_mismatch(chk_mismatch)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [32:0] sb_q [$];
  int unsigned enc_exp = 0, err_exp = 0;
  int          ready_mode = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [1:0] src, input logic [31:0] imm,
                                        input logic [31:0] base);
    logic [31:0] w;
    logic        e;
    case (src)
      2'b00: begin
        w = {imm[11:0], base[19:0]};
        e = !(imm[31:11] == '0 || imm[31:11] == '1);
      end
      2'b01: begin
        w = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        e = !(imm[31:11] == '0 || imm[31:11] == '1);
      end
      2'b10: begin
        w = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        e = !(imm[31:12] == '0 || imm[31:12] == '1) || imm[0];
      end
      default: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        e = !(imm[31:20] == '0 || imm[31:20] == '1) || imm[0];
      end
    endcase
    return {e, w};
  endfunction

  function automatic int unsigned sat(input int unsigned x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  // Consumer-side ready generator, updated just after each rising edge.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end
  end

  // Output monitor: compare every popped word against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_out", {31'b0, bus.out_valid}, 32'd0);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        check_eq("out_inst", bus.out_inst, e[31:0]);
        check_eq("out_err", {31'b0, bus.out_err}, {31'b0, e[32]});
      end
    end
  end

  // Drive one request and hold it until accepted (called just after a rising edge).
  task automatic send(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base);
    logic [32:0] e;
    bus.in_imm_src = src;
    bus.in_imm     = imm;
    bus.in_base    = base;
    bus.in_valid   = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        e = model(src, imm, base);
        sb_q.push_back(e);
        enc_exp++;
        if (e[32]) err_exp++;
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    check_eq("send_timeout", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    ready_mode = 1;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !bus.out_valid) return;
    end
    check_eq("drain_timeout", sb_q.size(), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    check_eq({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    check_eq({tag, "_out_inst"}, bus.out_inst, 32'd0);
    check_eq({tag, "_enc_cnt"}, {28'b0, enc_cnt}, 32'd0);
    check_eq({tag, "_err_cnt"}, {28'b0, err_cnt}, 32'd0);
    check_eq({tag, "_chk"}, {31'b0, chk_mismatch}, 32'd0);
  endtask

  initial begin
    logic [31:0] r, imm;
    logic [1:0]  src;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_imm_src = '0;
    bus.in_imm = '0;
    bus.in_base = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    // Directed vectors, including format boundaries.
    ready_mode = 1;
    @(posedge clk); #1;
    send(2'b00, 32'hFFFF_FFFF, 32'h0000_0013);
    @(negedge clk);
    check_eq("lat_out_valid", {31'b0, bus.out_valid}, 32'd1);
    check_eq("lat_out_inst", bus.out_inst, 32'hFFF0_0013);
    check_eq("lat_out_err", {31'b0, bus.out_err}, 32'd0);
    check_eq("lat_enc_cnt", {28'b0, enc_cnt}, 32'd1);
    @(posedge clk); #1;
    send(2'b10, 32'h0000_0FFE, 32'h0000_0063);
    send(2'b10, 32'h0000_0003, 32'h0000_0063);
    send(2'b11, 32'h0010_0000, 32'h0000_006F);
    send(2'b00, 32'd2047, 32'h0000_0013);
    send(2'b00, 32'd2048, 32'h0000_0013);
    send(2'b01, 32'hFFFF_F800, 32'h0000_2023);
    send(2'b01, 32'hFFFF_F7FF, 32'h0000_2023);
    send(2'b10, 32'hFFFF_F000, 32'hFFFF_FFFF);
    send(2'b11, 32'h000F_FFFE, 32'h0000_00EF);
    send(2'b11, 32'hFFF0_0000, 32'h0000_00EF);
    drain();
    check_eq("dir_enc_cnt", {28'b0, enc_cnt}, sat(enc_exp));
    check_eq("dir_err_cnt", {28'b0, err_cnt}, sat(err_exp));

    // Fill the FIFO with the consumer stalled.
    @(negedge clk) ready_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) send(2'b00, 32'(i + 5), 32'h0000_0013);
    @(negedge clk);
    check_eq("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check_eq("full_out_valid", {31'b0, bus.out_valid}, 32'd1);
    ready_mode = 1;
    @(negedge clk);
    check_eq("full_pop_in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    send(2'b01, 32'd77, 32'h0000_0023);
    drain();

    // Random traffic with random back-pressure; counters saturate.
    ready_mode = 2;
    @(posedge clk); #1;
    for (int i = 0; i < 300; i++) begin
      r   = $urandom;
      src = 2'($urandom_range(0, 3));
      case (src)
        2'b00, 2'b01: imm = {{20{r[11]}}, r[11:0]};
        2'b10:        imm = {{19{r[12]}}, r[12:1], 1'b0};
        default:      imm = {{11{r[20]}}, r[20:1], 1'b0};
      endcase
      if ($urandom_range(0, 9) == 0) imm = $urandom;
      send(src, imm, $urandom);
    end
    drain();
    check_eq("rnd_enc_cnt", {28'b0, enc_cnt}, sat(enc_exp));
    check_eq("rnd_err_cnt", {28'b0, err_cnt}, sat(err_exp));
    check_eq("rnd_chk", {31'b0, chk_mismatch}, 32'd0);

    // Asynchronous reset with words queued.
    @(negedge clk) ready_mode = 0;
    @(posedge clk); #1;
    send(2'b00, 32'd1, 32'h0000_0013);
    send(2'b00, 32'd2, 32'h0000_0013);
    #2 rst = 1'b1;
    sb_q.delete();
    enc_exp = 0;
    err_exp = 0;
    #1;
    check_idle("midrst");
    @(negedge clk) rst = 1'b0;
    ready_mode = 1;
    @(posedge clk); #1;
    send(2'b11, 32'h0000_0800, 32'h0000_006F);
    drain();
    check_eq("post_rst_enc_cnt", {28'b0, enc_cnt}, 32'd1);
    check_eq("post_rst_err_cnt", {28'b0, err_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
